// File: rtl/regfile_mov_ctrl_pkg.sv
// Shared definitions for the MOV controller: one-hot state encodings, opcode
// values, instruction field positions, shift codes and small decode helpers.
package regfile_mov_ctrl_pkg;

    typedef enum logic [5:0] {
        ST_WAIT   = 6'b000001,
        ST_DECODE = 6'b000010,
        ST_WR_IMM = 6'b000100,
        ST_RD_RM  = 6'b001000,
        ST_WR_RD  = 6'b010000,
        ST_DONE   = 6'b100000
    } state_t;

    localparam logic [2:0] OPCODE_MOV = 3'b110;
    localparam logic [1:0] OP_IMM     = 2'b10;
    localparam logic [1:0] OP_REG     = 2'b00;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    function automatic logic [15:0] signExt8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic isLegal(input logic [15:0] ins);
        return (ins[OPC_MSB:OPC_LSB] == OPCODE_MOV) &&
               ((ins[OP_MSB:OP_LSB] == OP_IMM) || (ins[OP_MSB:OP_LSB] == OP_REG));
    endfunction

endpackage

// File: rtl/regfile_mov_ctrl_mov_shifter.sv
// 16-bit single-position shifter applied to the Rm operand of MOV Rd,Rm{,sh}.
// Only instantiated when REGFILE_MOV_SHIFT_EN is defined.
import regfile_mov_ctrl_pkg::*;

module mov_shifter (
    input  logic [15:0] i_data,
    input  logic [1:0]  i_sh,
    output logic [15:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_sh)
            SH_NONE: o_data = i_data;
            SH_LSL:  o_data = {i_data[14:0], 1'b0};
            SH_LSR:  o_data = {1'b0, i_data[15:1]};
            SH_ASR:  o_data = {i_data[15], i_data[15:1]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/regfile_mov_ctrl.sv
// Multi-cycle controller sequencing an 8x16 register file for MOV Rn,#imm8 and
// MOV Rd,Rm{,sh}. Define REGFILE_MOV_SHIFT_EN to honour the sh field.
import regfile_mov_ctrl_pkg::*;

module regfile_mov_ctrl #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   instr,
    output logic          ready,
    output logic          done,
    output logic          illegal,
    output logic [DW-1:0] rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    input  logic [DW-1:0] rf_data_out
);

    state_t        r_state;
    logic [15:0]   r_ir;
    logic [DW-1:0] r_tmp;
    logic          r_ready;
    logic          r_done;
    logic          r_illegal;
    logic          r_write;
    logic [AW-1:0] r_writenum;
    logic [AW-1:0] r_readnum;
    logic [DW-1:0] w_shifted;
    logic [DW-1:0] w_dataIn;
    logic          w_isImm;
    logic          w_isReg;

`ifdef REGFILE_MOV_SHIFT_EN
    mov_shifter u_shifter (
        .i_data (rf_data_out),
        .i_sh   (r_ir[SH_MSB:SH_LSB]),
        .o_data (w_shifted)
    );
`else
    assign w_shifted = rf_data_out;
`endif

    assign w_isImm = isLegal(r_ir) && (r_ir[OP_MSB:OP_LSB] == OP_IMM);
    assign w_isReg = isLegal(r_ir) && (r_ir[OP_MSB:OP_LSB] == OP_REG);

    // Outputs are registered on entry to the state that owns them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT;
            r_ir       <= '0;
            r_tmp      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_write    <= 1'b0;
            r_writenum <= '0;
            r_readnum  <= '0;
        end else begin
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_write    <= 1'b0;
            r_writenum <= '0;
            r_readnum  <= '0;
            case (r_state)
                ST_WAIT: begin
                    if (start) begin
                        r_ir      <= instr;
                        r_illegal <= ~isLegal(instr);
                        r_state   <= ST_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_isImm) begin
                        r_write    <= 1'b1;
                        r_writenum <= r_ir[RN_MSB:RN_LSB];
                        r_state    <= ST_WR_IMM;
                    end else if (w_isReg) begin
                        r_readnum <= r_ir[RM_MSB:RM_LSB];
                        r_state   <= ST_RD_RM;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WR_IMM: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_RD_RM: begin
                    r_tmp      <= w_shifted;
                    r_write    <= 1'b1;
                    r_writenum <= r_ir[RD_MSB:RD_LSB];
                    r_state    <= ST_WR_RD;
                end
                ST_WR_RD: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    always_comb begin
        w_dataIn = '0;
        case (r_state)
            ST_WR_IMM: w_dataIn = signExt8(r_ir[IMM_MSB:IMM_LSB]);
            ST_WR_RD:  w_dataIn = r_tmp;
            default:   w_dataIn = '0;
        endcase
    end

    // Reset blocks the write port even in the cycle it is first asserted
    assign rf_write    = r_write & ~reset;
    assign rf_writenum = r_writenum;
    assign rf_readnum  = r_readnum;
    assign rf_data_in  = w_dataIn;
    assign ready       = r_ready;
    assign done        = r_done;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_regfile_mov_ctrl.sv
// Testbench for regfile_mov_ctrl: a behavioural register file plus an
// instruction-level reference model, driven by a vector table and random MOVs.
module tb_regfile_mov_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic        ready;
    logic        done;
    logic        illegal;
    logic [15:0] rf_data_in;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_out;

    logic [15:0] tbRf [8];
    logic        preEn;
    logic [2:0]  preIdx;
    logic [15:0] preVal;
    logic [15:0] mdl [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        int          preIdx;
        logic [15:0] preVal;
        int          chkIdx;
        logic [15:0] chkVal;
        bit          busy;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    regfile_mov_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .ready       (ready),
        .done        (done),
        .illegal     (illegal),
        .rf_data_in  (rf_data_in),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    // Register file model: combinational read, write on rising edge
    assign rf_data_out = tbRf[rf_readnum];

    always @(posedge clk) begin
        if (rf_write)
            tbRf[rf_writenum] <= rf_data_in;
        else if (preEn)
            tbRf[preIdx] <= preVal;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        preEn  = 1'b1;
        preIdx = idx;
        preVal = val;
        mdl[idx] = val;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Instruction-level reference: what the register file must hold afterwards
    task automatic modelExec(input logic [15:0] ins, output bit legal, output bit isReg);
        int v;
        legal = (ins[15:13] == 3'b110) && (ins[12:11] == 2'b10 || ins[12:11] == 2'b00);
        isReg = (ins[12:11] == 2'b00);
        if (legal && !isReg) begin
            v = int'(ins[7:0]);
            if (v >= 128) v = v - 256;
            mdl[ins[10:8]] = 16'(v);
        end else if (legal) begin
            v = int'(mdl[ins[2:0]]);
`ifdef REGFILE_MOV_SHIFT_EN
            case (ins[4:3])
                2'd1: v = (v * 2) % 65536;
                2'd2: v = v / 2;
                2'd3: v = v / 2 + ((v >= 32768) ? 32768 : 0);
                default: v = v;
            endcase
`endif
            mdl[ins[7:5]] = 16'(v);
        end
    endtask

    // Issue one instruction and observe cycles 1..8 after the accepting edge
    task automatic applyStimulus(input logic [15:0] ins, input bit busy,
                                 output int doneCyc, output int nDone, output int readyCyc,
                                 output int illCyc, output int nIll, output int nWrites);
        doneCyc = 0; nDone = 0; readyCyc = 0; illCyc = 0; nIll = 0; nWrites = 0;
        @(negedge clk);
        start = 1'b1;
        instr = ins;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                nDone++;
                if (doneCyc == 0) doneCyc = c;
            end
            if (illegal) begin
                nIll++;
                if (illCyc == 0) illCyc = c;
            end
            if (ready && readyCyc == 0) readyCyc = c;
            if (rf_write) nWrites++;
            if (busy && c <= 2) begin
                start = 1'b1;
                instr = ~ins;
            end else begin
                start = 1'b0;
                instr = 16'h0000;
            end
        end
    endtask

    task automatic runAndCheck(input logic [15:0] ins, input bit busy, input string tag);
        bit legal, isReg;
        int doneCyc, nDone, readyCyc, illCyc, nIll, nWrites;
        modelExec(ins, legal, isReg);
        applyStimulus(ins, busy && legal, doneCyc, nDone, readyCyc, illCyc, nIll, nWrites);
        checkOutput({tag, "_doneCycle"},  doneCyc,  !legal ? 0 : (isReg ? 4 : 3));
        checkOutput({tag, "_doneCount"},  nDone,    legal ? 1 : 0);
        checkOutput({tag, "_readyCycle"}, readyCyc, !legal ? 2 : (isReg ? 5 : 4));
        checkOutput({tag, "_illCycle"},   illCyc,   legal ? 0 : 1);
        checkOutput({tag, "_illCount"},   nIll,     legal ? 0 : 1);
        checkOutput({tag, "_writes"},     nWrites,  legal ? 1 : 0);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("%s_R%0d", tag, k), tbRf[k], mdl[k]);
    endtask

    initial begin
        int doneCnt, writeCnt, readyCnt;
        logic [15:0] ins;
        int kind;

`ifdef REGFILE_MOV_SHIFT_EN
        vecs[3] = '{16'hC0A8, 0, 16'h8001, 5, 16'h0002, 1'b0};
        vecs[4] = '{16'hC0B0, 0, 16'h8001, 5, 16'h4000, 1'b0};
        vecs[5] = '{16'hC0B8, 0, 16'h8001, 5, 16'hC000, 1'b0};
        vecs[6] = '{16'hC04A, 2, 16'h0003, 2, 16'h0006, 1'b1};
`else
        vecs[3] = '{16'hC0A8, 0, 16'h8001, 5, 16'h8001, 1'b0};
        vecs[4] = '{16'hC0B0, 0, 16'h8001, 5, 16'h8001, 1'b0};
        vecs[5] = '{16'hC0B8, 0, 16'h8001, 5, 16'h8001, 1'b0};
        vecs[6] = '{16'hC04A, 2, 16'h0003, 2, 16'h0003, 1'b1};
`endif
        vecs[0] = '{16'hD37F, -1, 16'h0000, 3, 16'h007F, 1'b0};
        vecs[1] = '{16'hD480, -1, 16'h0000, 4, 16'hFF80, 1'b1};
        vecs[2] = '{16'hC0A0, 0, 16'd64382, 5, 16'd64382, 1'b0};
        vecs[7] = '{16'h0000, -1, 16'h0000, -1, 16'h0000, 1'b0};
        vecs[8] = '{16'hC800, -1, 16'h0000, -1, 16'h0000, 1'b0};

        reset = 1'b1; start = 1'b0; instr = 16'h0000;
        preEn = 1'b0; preIdx = 3'd0; preVal = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready",    ready,       1);
        checkOutput("rst_done",     done,        0);
        checkOutput("rst_illegal",  illegal,     0);
        checkOutput("rst_write",    rf_write,    0);
        checkOutput("rst_writenum", rf_writenum, 0);
        checkOutput("rst_readnum",  rf_readnum,  0);
        checkOutput("rst_datain",   rf_data_in,  0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++)
            preload(3'(k), 16'(k * 4369 + 5));

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].preIdx >= 0)
                preload(3'(vecs[i].preIdx), vecs[i].preVal);
            runAndCheck(vecs[i].instr, vecs[i].busy, $sformatf("vec%0d", i));
            if (vecs[i].chkIdx >= 0)
                checkOutput($sformatf("vec%0d_target", i), tbRf[3'(vecs[i].chkIdx)], vecs[i].chkVal);
        end

        $display("[TB] reset during WR_IMM");
        preload(3'd7, 16'h1234);
        @(negedge clk); start = 1'b1; instr = 16'hD711;
        @(negedge clk); start = 1'b0; instr = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstMid_write", rf_write, 0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstMid_ready", ready, 1);
        doneCnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) doneCnt++;
            @(negedge clk);
        end
        checkOutput("rstMid_doneCount", doneCnt, 0);
        checkOutput("rstMid_R7", tbRf[7], 16'h1234);

        $display("[TB] reset together with start");
        @(negedge clk); reset = 1'b1; start = 1'b1; instr = 16'hD37F;
        @(negedge clk); reset = 1'b0; start = 1'b0; instr = 16'h0000;
        writeCnt = 0; readyCnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (rf_write) writeCnt++;
            if (ready) readyCnt++;
            @(negedge clk);
        end
        checkOutput("rstStart_writes", writeCnt, 0);
        checkOutput("rstStart_ready",  readyCnt, 4);
        checkOutput("rstStart_R3",     tbRf[3], mdl[3]);

        $display("[TB] random instructions");
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       ins = {5'b11010, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
                1, 2:    ins = {5'b11000, 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom)};
                default: ins = 16'($urandom);
            endcase
            runAndCheck(ins, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
